keyboard_buffer: RTL and testbench

KEYBOARD_BUFFER -- requirements
Module: keyboard_buffer

---
 rtl/drisc_io_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/keyboard_buffer.sv | 102 ++++++++++
 tb/tb_keyboard_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/drisc_io_pkg.sv
// Shared DRISC I/O definitions: user-input address window and the
// keyboard status-word field positions.
package drisc_io_pkg;

  localparam logic [31:0] USER_INPUT_BASE  = 32'h00ff_fffc;
  localparam logic [31:0] USER_INPUT_LIMIT = 32'h0100_0000;

  // Status word layout: {valid, 7'b0, overflow[7:0], 4'b0, occupancy[3:0], code[7:0]}
  localparam int unsigned VALID_BIT = 31;
  localparam int unsigned OVF_LSB   = 16;
  localparam int unsigned OCC_LSB   = 8;
  localparam int unsigned CODE_LSB  = 0;

  localparam int unsigned OVF_WIDTH = 8;
  localparam int unsigned OCC_WIDTH = 4;

  // Occupancy as shown in the status word, saturating at 4'hf.
  function automatic logic [3:0] occ_nibble(input logic [31:0] occ);
    return (occ > 32'd15) ? 4'hf : occ[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with one-bit-wider pointers; full/empty/count derive
// from pointer difference. Storage is not reset.
// Ports: clock, reset (sync, active-high), push/din write side,
//        pop/dout read side (dout shows head combinationally),
//        count (0..DEPTH), full, empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign count = r_wr_ptr - r_rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so push is allowed when full.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage write
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/keyboard_buffer.sv
// Memory-mapped keyboard buffer: queues key codes, counts dropped codes,
// and presents a status/key word for each processor read access.
// Ports: clock, reset (sync, active-high), key_strobe/key_code from the
//        keyboard front end, read (decoded access), data_out/data_out_enable
//        to the bus, key_available (FIFO non-empty).
module keyboard_buffer
  import drisc_io_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CODE_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_strobe,
  input  logic [CODE_WIDTH-1:0] key_code,
  input  logic                  read,
  output logic [31:0]           data_out,
  output logic                  data_out_enable,
  output logic                  key_available
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CODE_WIDTH-1:0] w_head;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_first;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_event;
  logic                  w_ovf_clear;
  logic [31:0]           w_word;

  logic                  r_read_q;
  logic [31:0]           r_hold;
  logic [OVF_WIDTH-1:0]  r_ovf;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_WIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (key_code),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // First cycle of a read access; reset masks read so an interrupted
  // access restarts afterwards.
  assign w_first     = read & ~r_read_q & ~reset;
  assign w_pop       = w_first & ~w_empty;
  assign w_push      = key_strobe & ~reset & (~w_full | w_pop);
  assign w_ovf_event = key_strobe & ~reset & w_full & ~w_pop;
  assign w_ovf_clear = w_first & (r_ovf != '0);

  // Status word from current FIFO state
  always_comb begin
    w_word                        = '0;
    w_word[VALID_BIT]             = ~w_empty;
    w_word[OVF_LSB +: OVF_WIDTH]  = r_ovf;
    w_word[OCC_LSB +: OCC_WIDTH]  = occ_nibble(32'(w_count));
    w_word[CODE_LSB +: 8]         = w_empty ? 8'h00 : 8'(w_head);
  end

  // Bus data: live word on the first cycle, held word afterwards
  always_comb begin
    data_out = '0;
    if (read && !reset) begin
      data_out = w_first ? w_word : r_hold;
    end
  end

  assign data_out_enable = read;
  assign key_available   = ~w_empty;

  // Access tracking, hold register and overflow counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_q <= 1'b0;
      r_hold   <= '0;
      r_ovf    <= '0;
    end else begin
      r_read_q <= read;
      if (w_first) begin
        r_hold <= w_word;
      end
      // Reporting a count clears it; a same-cycle drop restarts it at 1.
      if (w_ovf_clear) begin
        r_ovf <= w_ovf_event ? OVF_WIDTH'(1) : '0;
      end else if (w_ovf_event && (r_ovf != '1)) begin
        r_ovf <= r_ovf + OVF_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_keyboard_buffer.sv
// Scoreboard bench for keyboard_buffer: a queue-based reference model
// predicts each cycle's bus word and key_available; a negedge monitor
// pops and compares.
module tb_keyboard_buffer;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_strobe = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        read = 1'b0;
  logic [31:0] data_out;
  logic        data_out_enable;
  logic        key_available;

  int checks = 0;
  int errors = 0;

  keyboard_buffer #(.DEPTH(DEPTH), .CODE_WIDTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .key_strobe      (key_strobe),
    .key_code        (key_code),
    .read            (read),
    .data_out        (data_out),
    .data_out_enable (data_out_enable),
    .key_available   (key_available)
  );

  always #5 clock = ~clock;

  // Reference model state
  int          m_q[$];
  int          m_ovf = 0;
  bit          m_rq = 0;
  logic [31:0] m_hold = 32'h0;

  // Expected-value queues
  logic [31:0] eq[$];
  bit          kq[$];

  function automatic logic [31:0] model_word();
    int n = m_q.size();
    int occ = (n > 15) ? 15 : n;
    int code = (n != 0) ? m_q[0] : 0;
    int v = (n != 0) ? 1 : 0;
    return 32'(v) * 32'h8000_0000 + 32'(m_ovf) * 32'h1_0000 + 32'(occ) * 32'h100 + 32'(code);
  endfunction

  task automatic step(input bit rst, input bit st, input logic [7:0] cd,
                      input bit rd, input bit use_lit, input logic [31:0] lit);
    bit first, pop_now, full_now, drop, clr;
    @(posedge clock);
    #1;
    reset = rst; key_strobe = st; key_code = cd; read = rd;
    kq.push_back(m_q.size() != 0);
    if (rst) begin
      if (rd) eq.push_back(use_lit ? lit : 32'h0);
      m_q.delete();
      m_ovf = 0; m_rq = 0; m_hold = 32'h0;
      return;
    end
    first = rd && !m_rq;
    if (first) m_hold = model_word();
    if (rd) eq.push_back(use_lit ? lit : m_hold);
    pop_now  = first && (m_q.size() != 0);
    full_now = (m_q.size() == DEPTH);
    drop     = st && full_now && !pop_now;
    clr      = first && (m_ovf != 0);
    if (pop_now) void'(m_q.pop_front());
    if (st && !drop) m_q.push_back(int'(cd));
    if (clr) m_ovf = drop ? 1 : 0;
    else if (drop && m_ovf < 255) m_ovf = m_ovf + 1;
    m_rq = rd;
  endtask

  task automatic idle();          step(0, 0, 8'h00, 0, 0, 32'h0); endtask
  task automatic push(input logic [7:0] c); step(0, 1, c, 0, 0, 32'h0); endtask
  task automatic rd_lit(input logic [31:0] w); step(0, 0, 8'h00, 1, 1, w); endtask
  task automatic rd();            step(0, 0, 8'h00, 1, 0, 32'h0); endtask

  // Monitor: compares every modelled cycle at the falling edge
  always @(negedge clock) begin
    if (kq.size() > 0) begin
      bit kx;
      logic [31:0] wx;
      kx = kq.pop_front();
      checks++;
      if (key_available !== kx) begin
        errors++;
        $display("FAIL key_available got %0b want %0b at %0t", key_available, kx, $time);
      end
      if (data_out_enable) begin
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL word_missing got %08h want <none queued> at %0t", data_out, $time);
        end else begin
          wx = eq.pop_front();
          if (data_out !== wx) begin
            errors++;
            $display("FAIL data_out got %08h want %08h at %0t", data_out, wx, $time);
          end
        end
      end else begin
        checks++;
        if (data_out !== 32'h0) begin
          errors++;
          $display("FAIL data_out_idle got %08h want 00000000 at %0t", data_out, $time);
        end
      end
    end
  end

  initial begin
    int rd_left;
    // Reset
    step(1, 0, 8'h00, 0, 0, 32'h0);
    step(1, 0, 8'h00, 0, 0, 32'h0);

    // Read while empty
    rd_lit(32'h0000_0000);
    idle();

    // Two entries, two 2-cycle accesses
    push(8'h41); push(8'h42);
    rd_lit(32'h8000_0241); rd_lit(32'h8000_0241); idle();
    rd_lit(32'h8000_0142); rd_lit(32'h8000_0142); idle();
    idle();

    // Overflow by two, then report and clear
    for (int i = 1; i <= 10; i++) push(8'(i));
    rd_lit(32'h8002_0801); idle();
    rd_lit(32'h8000_0702); idle();
    for (int i = 0; i < 6; i++) begin rd(); idle(); end
    rd_lit(32'h0000_0000); idle();

    // Full FIFO with push in the pop cycle
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    step(0, 1, 8'h55, 1, 1, 32'h8000_0810); idle();
    rd_lit(32'h8000_0811); idle();
    for (int i = 0; i < 7; i++) begin rd(); idle(); end

    // Reset in the middle of a read access
    push(8'h61); push(8'h62); push(8'h63);
    rd_lit(32'h8000_0361);
    step(1, 0, 8'h00, 1, 1, 32'h0000_0000);
    rd_lit(32'h0000_0000);
    idle();

    // Saturating overflow counter
    for (int i = 0; i < 300; i++) push(8'(i + 1));
    rd_lit(32'h80ff_0801); idle();
    for (int i = 0; i < 8; i++) begin rd(); idle(); end

    // Randomised traffic
    rd_left = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, s, x;
      s = ($urandom_range(0, 99) < 45);
      x = ($urandom_range(0, 199) == 0);
      if (rd_left > 0) begin
        r = 1; rd_left--;
      end else if ($urandom_range(0, 99) < 25) begin
        r = 1; rd_left = $urandom_range(0, 2);
      end else begin
        r = 0;
      end
      step(x, s, 8'($urandom), r, 0, 32'h0);
    end
    idle(); idle();
    @(posedge clock);
    @(posedge clock);

    checks++;
    if (eq.size() != 0 || kq.size() != 0) begin
      errors++;
      $display("FAIL drain got eq=%0d kq=%0d want 0 0", eq.size(), kq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
